fetch_queue: RTL and testbench

Instruction-fetch front end that sits directly downstream of the PC register and upstream of decode. It drives `next_pc`/`pc_en` into the PC register and issues in-order instruction-memory reads at the current `pc`. Each request reserves a queue slot, and returned instructions are buffered and presented to decode with a valid/ready handshake. A branch/jump redirect flushes the queue and discards responses still in flight.

---
 rtl/fetch_queue_if.sv | 22 ++
 rtl/fetch_queue.sv | 174 +++++++++++++++++
 tb/tb_fetch_queue.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: in-order instruction-memory read port plus the
// valid/ready handshake that presents fetched instructions to decode.
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_rvalid, imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_rvalid, imem_rdata, if_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch queue between the PC register and decode, with redirect flush.
// Optional macro FETCH_BYPASS_EN forwards a head response to decode in its arrival cycle.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pc,
    output logic [31:0]   next_pc,
    output logic          pc_en,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    fetch_queue_if.master bus
);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DROP_W = PTR_W + 2;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic              alloc_q  [DEPTH];
    logic              alloc_d  [DEPTH];
    logic              filled_q [DEPTH];
    logic              filled_d [DEPTH];
    logic [31:0]       epc_q    [DEPTH];
    logic [31:0]       epc_d    [DEPTH];
    logic [31:0]       einstr_q [DEPTH];
    logic [31:0]       einstr_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              req_s, fill_ok_s, resp_fill_s, bypass_s, valid_s, pop_s;
    logic [CNT_W-1:0]  unfilled_s;
    logic [DROP_W:0]   drop_sum_s;

    // Count entries whose responses are still outstanding (become stale on redirect).
    always_comb begin
        unfilled_s = {CNT_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_q[i] && !filled_q[i]) begin
                unfilled_s = unfilled_s + CNT_W'(1);
            end else begin
                unfilled_s = unfilled_s;
            end
        end
    end

    // Request, response-steering and decode-side presentation decisions.
    always_comb begin
        req_s       = rst && !redirect_valid && (occ_q < DEPTH_C);
        fill_ok_s   = alloc_q[fill_q] && !filled_q[fill_q];
        resp_fill_s = bus.imem_rvalid && (drop_q == {DROP_W{1'b0}}) && fill_ok_s;
`ifdef FETCH_BYPASS_EN
        bypass_s    = resp_fill_s && (fill_q == head_q) && !redirect_valid;
        valid_s     = !redirect_valid && ((alloc_q[head_q] && filled_q[head_q]) || bypass_s);
`else
        bypass_s    = 1'b0;
        valid_s     = alloc_q[head_q] && filled_q[head_q];
`endif
        pop_s       = valid_s && bus.if_ready && !redirect_valid;
    end

    assign bus.imem_req  = req_s;
    assign bus.imem_addr = pc;
    assign pc_en         = rst && (req_s || redirect_valid);
    assign next_pc       = !rst ? 32'd0 : (redirect_valid ? redirect_pc : pc + 32'd4);
    assign bus.if_valid  = valid_s;
    assign bus.if_pc     = alloc_q[head_q] ? epc_q[head_q] : 32'd0;
    assign bus.if_instr  = bypass_s ? bus.imem_rdata :
                           (alloc_q[head_q] ? einstr_q[head_q] : 32'd0);

    // Next-state for entries, pointers, occupancy and stale-response count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            alloc_d[i]  = alloc_q[i];
            filled_d[i] = filled_q[i];
            epc_d[i]    = epc_q[i];
            einstr_d[i] = einstr_q[i];
        end
        head_d = head_q;
        tail_d = tail_q;
        fill_d = fill_q;
        occ_d  = occ_q;
        drop_d = drop_q;
        drop_sum_s = {1'b0, drop_q} + (DROP_W+1)'(unfilled_s);
        if (bus.imem_rvalid && (drop_sum_s != {(DROP_W+1){1'b0}})) begin
            drop_sum_s = drop_sum_s - (DROP_W+1)'(1);
        end else begin
            drop_sum_s = drop_sum_s;
        end

        if (redirect_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                alloc_d[i]  = 1'b0;
                filled_d[i] = 1'b0;
                epc_d[i]    = 32'd0;
                einstr_d[i] = 32'd0;
            end
            head_d = {PTR_W{1'b0}};
            tail_d = {PTR_W{1'b0}};
            fill_d = {PTR_W{1'b0}};
            occ_d  = {CNT_W{1'b0}};
            // Stale responses may outlive several redirects; hold at the ceiling rather than wrap.
            drop_d = drop_sum_s[DROP_W] ? DROP_MAX : drop_sum_s[DROP_W-1:0];
        end else begin
            if (req_s) begin
                alloc_d[tail_q]  = 1'b1;
                filled_d[tail_q] = 1'b0;
                epc_d[tail_q]    = pc;
                einstr_d[tail_q] = 32'd0;
                tail_d           = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end

            if (bus.imem_rvalid && (drop_q != {DROP_W{1'b0}})) begin
                drop_d = drop_q - DROP_W'(1);
            end else if (resp_fill_s) begin
                einstr_d[fill_q] = bus.imem_rdata;
                filled_d[fill_q] = 1'b1;
                fill_d           = fill_q + PTR_W'(1);
            end else begin
                drop_d = drop_q;
            end

            // Pop after the fill write so a bypassed head entry is cleared, never kept.
            if (pop_s) begin
                alloc_d[head_q]  = 1'b0;
                filled_d[head_q] = 1'b0;
                epc_d[head_q]    = 32'd0;
                einstr_d[head_q] = 32'd0;
                head_d           = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end

            case ({req_s, pop_s})
                2'b10:   occ_d = occ_q + CNT_W'(1);
                2'b01:   occ_d = occ_q - CNT_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                alloc_q[i]  <= 1'b0;
                filled_q[i] <= 1'b0;
                epc_q[i]    <= 32'd0;
                einstr_q[i] <= 32'd0;
            end
            head_q <= {PTR_W{1'b0}};
            tail_q <= {PTR_W{1'b0}};
            fill_q <= {PTR_W{1'b0}};
            occ_q  <= {CNT_W{1'b0}};
            drop_q <= {DROP_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                alloc_q[i]  <= alloc_d[i];
                filled_q[i] <= filled_d[i];
                epc_q[i]    <= epc_d[i];
                einstr_q[i] <= einstr_d[i];
            end
            head_q <= head_d;
            tail_q <= tail_d;
            fill_q <= fill_d;
            occ_q  <= occ_d;
            drop_q <= drop_d;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: PC register and in-order memory are modelled here;
// instruction words returned by the memory are the bitwise inverse of their address.
module tb_fetch_queue;
    logic        clk, rst;
    logic [31:0] pc, next_pc, redirect_pc;
    logic        pc_en, redirect_valid;

    fetch_queue_if bus();

    fetch_queue #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst), .pc(pc), .next_pc(next_pc), .pc_en(pc_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .bus(bus)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mem_q[$];

    int cyc, lat, checks, failures;
    logic        s_req, s_pc_en, s_rvalid, s_valid;
    logic [31:0] s_addr, s_next_pc, s_ipc, s_instr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Sample cycle values, advance one edge, then update PC register and memory model.
    task automatic tick();
        mreq_t m;
        #1;
        s_req = bus.imem_req;     s_addr = bus.imem_addr;
        s_pc_en = pc_en;          s_next_pc = next_pc;
        s_rvalid = bus.imem_rvalid;
        s_valid = bus.if_valid;   s_ipc = bus.if_pc;   s_instr = bus.if_instr;
        if (s_rvalid) assert (mem_q.size() > 0) else $error("FAIL proto: rvalid with no outstanding request");
        @(posedge clk);
        cyc++;
        #1;
        if (s_pc_en) pc = s_next_pc;
        if (s_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
        if (s_req) begin
            m.addr = s_addr; m.due = cyc + lat;
            mem_q.push_back(m);
        end
        if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
            bus.imem_rvalid = 1'b1; bus.imem_rdata = ~mem_q[0].addr;
        end else begin
            bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; pc = 32'd0;
        bus.if_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
        mem_q.delete();
        @(posedge clk); #1;
        rst = 1'b1; cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40; pc = 32'h0;
        bus.if_ready = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
        @(posedge clk); #1;
        checks++;
        if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'd0 || bus.if_pc !== 32'd0) begin
            failures++;
            $display("FAIL reset_if: valid=%b instr=%h pc=%h expected 0/0/0", bus.if_valid, bus.if_instr, bus.if_pc);
        end
        checks++;
        if (bus.imem_req !== 1'b0 || pc_en !== 1'b0 || next_pc !== 32'd0) begin
            failures++;
            $display("FAIL reset_req: req=%b pc_en=%b next_pc=%h expected 0/0/0", bus.imem_req, pc_en, next_pc);
        end
        redirect_valid = 1'b0; rst = 1'b1; #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0 || next_pc !== 32'd4) begin
            failures++;
            $display("FAIL reset_release: req=%b addr=%h next_pc=%h expected 1/0/4", bus.imem_req, bus.imem_addr, next_pc);
        end
    endtask

    task automatic test_stream();
        logic        e_req [7];
        logic [31:0] e_addr[7];
        logic        e_val [7];
        logic [31:0] e_pc  [7];
`ifdef FETCH_BYPASS_EN
        e_req  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        e_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};
        e_val  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        e_pc   = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
`else
        e_req  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        e_addr = '{32'h0, 32'h4, 32'h0, 32'h8, 32'hC, 32'h0, 32'h10};
        e_val  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        e_pc   = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'h8, 32'hC};
`endif
        do_reset(); lat = 1; bus.if_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (s_req !== e_req[k] || s_pc_en !== e_req[k]) begin
                failures++;
                $display("FAIL stream_req c%0d: req=%b pc_en=%b expected %b", k+1, s_req, s_pc_en, e_req[k]);
            end
            if (e_req[k]) begin
                checks++;
                if (s_addr !== e_addr[k]) begin
                    failures++;
                    $display("FAIL stream_addr c%0d: got %h expected %h", k+1, s_addr, e_addr[k]);
                end
            end
            checks++;
            if (s_valid !== e_val[k] || s_ipc !== e_pc[k]) begin
                failures++;
                $display("FAIL stream_out c%0d: valid=%b pc=%h expected %b/%h", k+1, s_valid, s_ipc, e_val[k], e_pc[k]);
            end
            if (e_val[k]) begin
                checks++;
                if (s_instr !== ~e_pc[k]) begin
                    failures++;
                    $display("FAIL stream_instr c%0d: got %h expected %h", k+1, s_instr, ~e_pc[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic        e_req [7];
        logic [31:0] e_addr[7];
        logic [31:0] e_pc  [7];
        e_req  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        e_addr = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h8, 32'hC};
        e_pc   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0};
        do_reset(); lat = 1;
        for (int k = 0; k < 7; k++) begin
            bus.if_ready = (k >= 4);
            tick();
            checks++;
            if (s_req !== e_req[k] || s_pc_en !== e_req[k]) begin
                failures++;
                $display("FAIL bp_req c%0d: req=%b pc_en=%b expected %b", k+1, s_req, s_pc_en, e_req[k]);
            end
            if (e_req[k]) begin
                checks++;
                if (s_addr !== e_addr[k]) begin
                    failures++;
                    $display("FAIL bp_addr c%0d: got %h expected %h", k+1, s_addr, e_addr[k]);
                end
            end
            if (k >= 2 && k <= 5) begin
                checks++;
                if (s_valid !== 1'b1 || s_ipc !== e_pc[k]) begin
                    failures++;
                    $display("FAIL bp_out c%0d: valid=%b pc=%h expected 1/%h", k+1, s_valid, s_ipc, e_pc[k]);
                end
            end
        end
    endtask

    task automatic test_redirect_drop();
        int first;
`ifdef FETCH_BYPASS_EN
        first = 7;
`else
        first = 8;
`endif
        do_reset(); lat = 3; bus.if_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            redirect_valid = (c == 3); redirect_pc = 32'h100;
            tick();
            if (c == 3) begin
                checks++;
                if (s_req !== 1'b0 || s_pc_en !== 1'b1 || s_next_pc !== 32'h100) begin
                    failures++;
                    $display("FAIL redir_cycle: req=%b pc_en=%b next_pc=%h expected 0/1/100", s_req, s_pc_en, s_next_pc);
                end
            end
            if (c == 4 || c == 5) begin
                checks++;
                if (s_req !== 1'b1 || s_addr !== 32'h100 + 32'(4 * (c - 4))) begin
                    failures++;
                    $display("FAIL redir_req c%0d: req=%b addr=%h expected 1/%h", c, s_req, s_addr, 32'h100 + 32'(4 * (c - 4)));
                end
            end
            if (c < first) begin
                checks++;
                if (s_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL redir_stale c%0d: valid=%b pc=%h expected valid 0", c, s_valid, s_ipc);
                end
            end else begin
                checks++;
                if (s_valid !== 1'b1 || s_ipc !== 32'h100 + 32'(4 * (c - first)) || s_instr !== ~(32'h100 + 32'(4 * (c - first)))) begin
                    failures++;
                    $display("FAIL redir_out c%0d: valid=%b pc=%h instr=%h expected pc %h", c, s_valid, s_ipc, s_instr, 32'h100 + 32'(4 * (c - first)));
                end
            end
            if (c == first + 1) break;
        end
    endtask

    task automatic test_redirect_rvalid();
        int first;
`ifdef FETCH_BYPASS_EN
        first = 7;
`else
        first = 8;
`endif
        do_reset(); lat = 2;
        for (int c = 1; c <= 8; c++) begin
            bus.if_ready = (c >= 4);
            redirect_valid = (c == 4); redirect_pc = 32'h200;
            tick();
            if (c == 4) begin
                checks++;
                if (s_req !== 1'b0 || s_pc_en !== 1'b1 || s_next_pc !== 32'h200) begin
                    failures++;
                    $display("FAIL redrv_cycle: req=%b pc_en=%b next_pc=%h expected 0/1/200", s_req, s_pc_en, s_next_pc);
                end
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (s_req !== 1'b1 || s_addr !== 32'h200 + 32'(4 * (c - 5))) begin
                    failures++;
                    $display("FAIL redrv_req c%0d: req=%b addr=%h expected 1/%h", c, s_req, s_addr, 32'h200 + 32'(4 * (c - 5)));
                end
            end
            if (c >= 5 && c < first) begin
                checks++;
                if (s_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL redrv_stale c%0d: valid=%b pc=%h expected valid 0", c, s_valid, s_ipc);
                end
            end
            if (c == first) begin
                checks++;
                if (s_valid !== 1'b1 || s_ipc !== 32'h200 || s_instr !== ~32'h200) begin
                    failures++;
                    $display("FAIL redrv_out c%0d: valid=%b pc=%h instr=%h expected 1/200/%h", c, s_valid, s_ipc, s_instr, ~32'h200);
                end
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        do_reset(); lat = 1; bus.if_ready = 1'b1; pc = 32'hFFFF_FFFC;
        tick();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC || s_next_pc !== 32'h0) begin
            failures++;
            $display("FAIL wrap_c1: req=%b addr=%h next_pc=%h expected 1/fffffffc/0", s_req, s_addr, s_next_pc);
        end
        tick();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0 || s_next_pc !== 32'h4) begin
            failures++;
            $display("FAIL wrap_c2: req=%b addr=%h next_pc=%h expected 1/0/4", s_req, s_addr, s_next_pc);
        end
        #1;
        checks++;
        if (bus.if_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: valid=%b expected 1", bus.if_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0 || dut.occ_q !== 2'd0) begin
            failures++;
            $display("FAIL midrst_clear: valid=%b req=%b occ=%0d expected 0/0/0", bus.if_valid, bus.imem_req, dut.occ_q);
        end
        checks++;
        if (pc_en !== 1'b0 || next_pc !== 32'd0 || bus.if_pc !== 32'd0 || bus.if_instr !== 32'd0) begin
            failures++;
            $display("FAIL midrst_out: pc_en=%b next_pc=%h if_pc=%h instr=%h expected zeros", pc_en, next_pc, bus.if_pc, bus.if_instr);
        end
        mem_q.delete(); bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0; pc = 32'h0;
        @(posedge clk); #1;
        rst = 1'b1; cyc = 0;
        tick();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_restart: req=%b addr=%h valid=%b expected 1/0/0", s_req, s_addr, s_valid);
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; lat = 1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_rvalid();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
